mem_stage_bus_if: RTL and testbench

- Sequential bridge between the memory stage's shared-memory outputs (mask, address, write data) and the shared data-memory bus.
- Sits directly downstream of the memory stage.
- Converts the single-cycle dm_en access into a req/gnt/rvalid transaction.
- Holds the pipeline via stall_o until the access completes, and returns load data to the memory stage for LSU formatting.

---
 rtl/mem_stage_bus_if.sv | 131 +++++++++++++
 tb/tb_mem_stage_bus_if.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_bus_if.sv
// Bridges the memory stage's single-cycle dm_en access onto a req/gnt/rvalid
// data-memory bus, stalling the pipeline until the access completes or times out.
module mem_stage_bus_if #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  mask_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_mask_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_flushed;
    logic               w_last;
    logic               w_stall;

    // Final cycle of the REQ+WAIT budget
    assign w_last = (r_cnt == CNT_W'(TIMEOUT - 1));

    // Stall is combinational so the access is held in the cycle it is first seen
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_IDLE:  w_stall = req_i & ~flush_i;
            S_REQ:   w_stall = ~(flush_i & ~bus_gnt_i);
            S_WAIT:  w_stall = 1'b1;
            default: w_stall = 1'b0;
        endcase
    end

    assign stall_o = arst_n & w_stall;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_flushed     <= 1'b0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
            err_o         <= 1'b0;
            bus_req_o     <= 1'b0;
            bus_we_o      <= 1'b0;
            bus_mask_o    <= '0;
            bus_addr_o    <= '0;
            bus_wdata_o   <= '0;
        end else begin
            rdata_valid_o <= 1'b0;
            err_o         <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_i && !flush_i) begin
                        r_state     <= S_REQ;
                        r_cnt       <= '0;
                        r_flushed   <= 1'b0;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= we_i;
                        bus_mask_o  <= mask_i;
                        bus_addr_o  <= addr_i;
                        bus_wdata_o <= wdata_i;
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Grant beats a same-cycle flush; the access then completes as flushed
                    if (bus_gnt_i) begin
                        bus_req_o <= 1'b0;
                        r_flushed <= flush_i;
                        if (bus_we_o) begin
                            r_state <= S_DONE;
                        end else if (w_last) begin
                            r_state <= S_DONE;
                            rdata_o <= '0;
                            err_o   <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else if (flush_i) begin
                        bus_req_o <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (w_last) begin
                        bus_req_o <= 1'b0;
                        r_state   <= S_DONE;
                        rdata_o   <= '0;
                        err_o     <= 1'b1;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (bus_rvalid_i) begin
                        rdata_o       <= bus_rdata_i;
                        rdata_valid_o <= ~r_flushed;
                        r_state       <= S_DONE;
                    end else if (w_last) begin
                        rdata_o <= '0;
                        err_o   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_bus_if.sv
// Randomized bench for mem_stage_bus_if: each access is planned as a transaction
// whose outcome (phase lengths, flags, data) is derived arithmetically up front.
module tb_mem_stage_bus_if;

    localparam int T     = 8;
    localparam int NEVER = 1000;

    logic        clk;
    logic        arst_n;
    logic        req_i, we_i, flush_i;
    logic [3:0]  mask_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, rdata_valid_o, err_o;
    logic [31:0] rdata_o;
    logic        bus_req_o, bus_we_o;
    logic [3:0]  bus_mask_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    int          n_vec;
    int          n_err;
    logic [31:0] exp_rdata;

    mem_stage_bus_if #(.TIMEOUT(T)) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .req_i         (req_i),
        .we_i          (we_i),
        .mask_i        (mask_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .err_o         (err_o),
        .bus_req_o     (bus_req_o),
        .bus_we_o      (bus_we_o),
        .bus_mask_o    (bus_mask_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_gnt_i     (bus_gnt_i),
        .bus_rvalid_i  (bus_rvalid_i),
        .bus_rdata_i   (bus_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs(input string ph, input logic stall, input logic breq,
                              input logic rv, input logic err);
        check_eq({ph, ".stall"}, 32'(stall_o), 32'(stall));
        check_eq({ph, ".bus_req"}, 32'(bus_req_o), 32'(breq));
        check_eq({ph, ".rdata_valid"}, 32'(rdata_valid_o), 32'(rv));
        check_eq({ph, ".err"}, 32'(err_o), 32'(err));
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic scramble_core;
        we_i    = 1'($urandom);
        mask_i  = 4'($urandom);
        addr_i  = $urandom;
        wdata_i = $urandom;
    endtask

    // gd/fa: REQ-cycle index of grant/flush; rd: WAIT-cycle index of rvalid (NEVER = none)
    task automatic do_txn(input logic we, input logic [3:0] mask, input logic [31:0] addr,
                          input logic [31:0] wdata, input int gd, input int fa, input int rd,
                          input logic [31:0] rdat, input logic done_req, input int gap,
                          input logic noisy_gap);
        int  endr, endw;
        bit  granted, flushed, dropped, tmo, waits;
        endr    = imin(imin(gd, fa), T - 1);
        granted = (gd == endr);
        flushed = granted && (fa == endr);
        dropped = !granted && (fa == endr);
        tmo     = 1'b0;
        waits   = 1'b0;
        endw    = 0;
        if (granted && !we) begin
            if (endr == T - 1) tmo = 1'b1;
            else waits = 1'b1;
        end else if (!granted && !dropped) begin
            tmo = 1'b1;
        end
        if (waits) begin
            endw = imin(rd, T - 2 - endr);
            if (endw != rd) tmo = 1'b1;
        end

        req_i = 1'b1; flush_i = 1'b0; we_i = we; mask_i = mask; addr_i = addr; wdata_i = wdata;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        #1;
        check_outs("idle", 1'b1, 1'b0, 1'b0, 1'b0);
        next_cycle();

        req_i = 1'b0;
        for (int r = 0; r <= endr; r++) begin
            scramble_core();
            bus_gnt_i = (r == gd);
            flush_i   = (r == fa);
            #1;
            check_outs("req", !(dropped && r == endr), 1'b1, 1'b0, 1'b0);
            check_eq("req.we", 32'(bus_we_o), 32'(we));
            check_eq("req.mask", 32'(bus_mask_o), 32'(mask));
            check_eq("req.addr", bus_addr_o, addr);
            check_eq("req.wdata", bus_wdata_o, wdata);
            next_cycle();
        end
        bus_gnt_i = 1'b0;
        flush_i   = 1'b0;

        if (waits) begin
            for (int w = 0; w <= endw; w++) begin
                bus_rvalid_i = (w == rd);
                bus_rdata_i  = (w == rd) ? rdat : $urandom;
                #1;
                check_outs("wait", 1'b1, 1'b0, 1'b0, 1'b0);
                next_cycle();
            end
            bus_rvalid_i = 1'b0;
            if (!tmo) exp_rdata = rdat;
        end
        if (tmo) exp_rdata = 32'h0;

        if (!dropped) begin
            req_i = done_req;
            scramble_core();
            #1;
            check_outs("done", 1'b0, 1'b0, !we && !flushed && !tmo, tmo);
            check_eq("done.rdata", rdata_o, exp_rdata);
            next_cycle();
            req_i = 1'b0;
        end

        for (int g = 0; g < gap; g++) begin
            req_i        = noisy_gap && ($urandom_range(0, 2) == 0);
            flush_i      = req_i;
            bus_rvalid_i = noisy_gap && ($urandom_range(0, 1) == 0);
            bus_rdata_i  = $urandom;
            scramble_core();
            #1;
            check_outs("gap", 1'b0, 1'b0, 1'b0, 1'b0);
            check_eq("gap.rdata", rdata_o, exp_rdata);
            next_cycle();
        end
        req_i = 1'b0; flush_i = 1'b0; bus_rvalid_i = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        exp_rdata = 32'h0;
        arst_n = 1'b0;
        req_i = 1'b0; we_i = 1'b0; flush_i = 1'b0; mask_i = '0; addr_i = '0; wdata_i = '0;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
        #23;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("reset.rdata", rdata_o, 32'h0);
        check_eq("reset.bus_addr", bus_addr_o, 32'h0);
        next_cycle();
        arst_n = 1'b1;
        next_cycle();

        do_txn(1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 0, NEVER, NEVER, 32'h0, 1'b0, 1, 1'b0);
        do_txn(1'b0, 4'hF, 32'h0000_0200, 32'h0, 2, NEVER, 1, 32'h1234_5678, 1'b0, 3, 1'b0);
        do_txn(1'b1, 4'h3, 32'h0000_0300, 32'hCAFE_F00D, NEVER, 1, NEVER, 32'h0, 1'b0, 2, 1'b0);
        do_txn(1'b0, 4'hF, 32'h0000_0400, 32'h0, 0, 0, 1, 32'hA5A5_5A5A, 1'b0, 1, 1'b0);
        do_txn(1'b0, 4'hF, 32'h0000_0500, 32'h0, 0, NEVER, NEVER, 32'h0, 1'b0, 3, 1'b1);
        do_txn(1'b1, 4'h0, 32'h0000_0600, 32'h1111_2222, 1, NEVER, NEVER, 32'h0, 1'b1, 0, 1'b0);
        do_txn(1'b0, 4'hC, 32'h0000_0700, 32'h0, 0, NEVER, 0, 32'h8765_4321, 1'b1, 1, 1'b0);

        // Asynchronous reset while a load sits in WAIT
        req_i = 1'b1; we_i = 1'b0; mask_i = 4'hF; addr_i = 32'h0000_0800;
        next_cycle();
        req_i = 1'b0; bus_gnt_i = 1'b1;
        next_cycle();
        bus_gnt_i = 1'b0;
        #1;
        check_eq("rstwait.pre_stall", 32'(stall_o), 32'h1);
        arst_n = 1'b0;
        #1;
        check_outs("rstwait", 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rstwait.rdata", rdata_o, 32'h0);
        exp_rdata = 32'h0;
        next_cycle();
        next_cycle();
        arst_n = 1'b1;
        check_outs("postrst", 1'b0, 1'b0, 1'b0, 1'b0);
        do_txn(1'b0, 4'hF, 32'h0000_0900, 32'h0, 1, NEVER, 2, 32'h0BAD_F00D, 1'b0, 1, 1'b0);

        for (int i = 0; i < 80; i++) begin
            int gd, fa, rd;
            gd = $urandom_range(0, 9);
            fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : NEVER;
            rd = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, 3));
            do_txn(1'($urandom), 4'($urandom), $urandom, $urandom, gd, fa, rd, $urandom,
                   1'($urandom), int'($urandom_range(0, 2)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
